// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer.
// Flush and bubbles zero the control field; payload data is left untouched.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  state_t state;
  ent_t   head, skid, in_ent;
  logic   rdy_q, accept, fire;

  assign in_ent    = '{data: in_data, ctrl: in_ctrl};
  assign out_valid = (state != EMPTY);
  assign fire      = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_data  = head.data;
  assign out_ctrl  = out_valid ? head.ctrl : '0;
  assign occupancy = state;

  // Skid mode keeps in_ready fully registered; the bare register needs the
  // combinational form to sustain one entry per cycle.
  assign in_ready  = (SKID != 0) ? rdy_q : (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      rdy_q <= 1'b1;
    end else if (flush) begin
      // Held entries become bubbles; data fields keep their last value.
      state     <= EMPTY;
      head.ctrl <= '0;
      skid.ctrl <= '0;
      rdy_q     <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= in_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            head <= in_ent;
          end else if (accept && (SKID != 0)) begin
            skid  <= in_ent;
            state <= TWO;
            rdy_q <= 1'b0;
          end else if (fire) begin
            head.ctrl <= '0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            head      <= skid;
            skid.ctrl <= '0;
            state     <= ONE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register. It is the next-generation replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width data field and an arbitrary-width control field.
- Uses a valid/ready handshake instead of a bare enable, and has an optional 2-entry skid buffer so the back-pressure path is fully registered.
- Flush zeroes the control field, turning the stage contents into bubbles.

Parameters:
- DATA_W, 96: width of the payload (operands, PC, immediates, register indices); not cleared on flush.
- CTRL_W, 16: width of the control field (regWrite, memWrite, branch, jump, ALU control, ...); zeroed on flush and on bubbles.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous flush: discard all held entries
- in_valid  in  1  upstream stage presents a valid entry
- in_ready  out  1  this stage accepts the entry this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  out_data/out_ctrl hold a valid entry
- out_ready  in  1  downstream stage consumes the entry this cycle
- out_data  out  DATA_W  payload of the head entry
- out_ctrl  out  CTRL_W  control of the head entry; all-zero whenever out_valid=0
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Handshake events:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - in_valid may be raised without waiting for in_ready. An offered entry must be held stable until accepted.
- Reset (rst=0, asynchronous):
  - State EMPTY; out_valid=0, out_data=0, out_ctrl=0, skid registers=0, occupancy=0.
  - in_ready=1 after reset releases.
- States (SKID=1): EMPTY (occ 0), ONE (head full), TWO (head and skid full).
- State transitions, one per rising edge; flush has priority over everything:
  - EMPTY: accept -> ONE, head<=in. in_ready=1.
  - ONE, accept & fire -> ONE, head<=in.
  - ONE, accept & !fire -> TWO, skid<=in.
  - ONE, !accept & fire -> EMPTY.
  - ONE, no event -> hold. in_ready=1.
  - TWO: in_ready=0 (no accept possible). Fire -> ONE, head<=skid. No fire -> hold.
- in_ready (SKID=1):
  - Registered, equal to (next state != TWO).
  - No combinational path from out_ready to in_ready.
- Latency and ordering:
  - An entry accepted at edge N is visible on out_* after edge N (1 cycle) when the stage was empty or firing.
  - Otherwise the entry waits in skid. Ordering is strictly FIFO.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Flush (flush=1 at the edge):
  - Next state EMPTY; out_valid=0, out_ctrl=0, skid ctrl=0.
  - out_data and skid data keep their values.
  - An input offered that cycle is NOT captured, even if in_ready=1. A downstream fire in that same cycle is still considered consumed.
  - in_ready=1 on the following cycle.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0, so downstream never sees stale regWrite/memWrite.
- SKID=0 mode:
  - Only the head register exists; occupancy is 0 or 1.
  - in_ready = !out_valid | out_ready (combinational). Accept loads head.
  - Fire without accept -> EMPTY.
  - Flush, reset and bubble rules are identical to SKID=1.
- Reset mid-operation: an asynchronous clear from any state. Held entries are lost, with no partial outputs.
- No overflow is possible: the TWO state blocks accept. Underflow: fire requires out_valid.

Test Plan:
- Reset then stream (SKID=1): rst low, then release; drive in_valid=1 with data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting one cycle after first accept; occupancy stays 1; in_ready stays 1.
- Back-pressure fill: out_ready=0, offer A=0x11, B=0x22, C=0x33 -> A and B accepted, occupancy=2, in_ready=0, C held upstream. Then raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush with full skid: state TWO (ctrl=0xFFFF in both entries), flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x0000, occupancy=0, offered entry not captured, in_ready=1.
- Simultaneous accept and fire in ONE: head=0xAA, offer 0xBB, out_ready=1 -> next cycle out_data=0xBB, occupancy=1, no transition to TWO.
- Async reset mid-traffic: assert rst between clock edges while occupancy=2 -> out_valid, out_ctrl and occupancy go to 0 immediately, without waiting for a clock edge; in_ready=1 after release.
- SKID=0 instance: out_ready=0, out_valid=1 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and the new entry loads on that edge.
